// File: rtl/uart_msg_parser.sv
// uart_msg_parser: pops bytes from a UART RX FIFO and decodes SYNC/TYPE/PRICE/QTY[/CHK] frames.
// Optional build macro UART_MSG_PARSER_CHKSUM_EN adds a trailing XOR checksum byte (7-byte frames);
// without it, frames are 6 bytes and only inter-byte timeouts count as errors.
module uart_msg_parser #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [19:0] TIMEOUT   = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  r_data,
    input  logic        rx_empty,
    output logic        rd_uart,
    output logic        msg_valid,
    output logic [7:0]  msg_type,
    output logic [15:0] price,
    output logic [15:0] qty,
    output logic [7:0]  err_cnt,
    output logic        busy
);
    typedef enum logic [2:0] {HUNT, TYPE, PAYLOAD, CHK, DONE} state_t;

    state_t      state;
    logic        rd_prev;
    logic [1:0]  idx;
    logic [7:0]  xsum;
    logic [7:0]  type_sh;
    logic [15:0] price_sh;
    logic [15:0] qty_sh;
    logic [19:0] timer;
    logic        in_frame;
    logic        expired;

    // Pop whenever data is present, but never on two consecutive cycles and never while in reset.
    assign rd_uart  = reset_n && !rx_empty && !rd_prev;
    assign busy     = state != HUNT;
    assign in_frame = state == TYPE || state == PAYLOAD || state == CHK;
    // A pop in the same cycle as expiry takes priority, so expiry requires no pop.
    assign expired  = in_frame && timer == TIMEOUT && !rd_uart;

    // Remember last cycle's pop to throttle to one byte per two cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_prev <= 1'b0;
        else          rd_prev <= rd_uart;
    end

    // Frame FSM, inter-byte timer, shadow fields and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            idx       <= '0;
            xsum      <= '0;
            type_sh   <= '0;
            price_sh  <= '0;
            qty_sh    <= '0;
            timer     <= '0;
            msg_valid <= 1'b0;
            msg_type  <= '0;
            price     <= '0;
            qty       <= '0;
            err_cnt   <= '0;
        end else begin
            msg_valid <= 1'b0;
            timer     <= (rd_uart || !in_frame || expired) ? '0 : timer + 1'b1;
            if (expired) begin
                state   <= HUNT;
                err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
            end else if (rd_uart) begin
                case (state)
                    TYPE: begin
                        type_sh <= r_data;
                        xsum    <= r_data;
                        idx     <= '0;
                        state   <= PAYLOAD;
                    end
                    PAYLOAD: begin
                        xsum <= xsum ^ r_data;
                        idx  <= idx + 1'b1;
                        if (idx[1]) qty_sh   <= {qty_sh[7:0], r_data};
                        else        price_sh <= {price_sh[7:0], r_data};
                        if (idx == 2'd3) begin
`ifdef UART_MSG_PARSER_CHKSUM_EN
                            state     <= CHK;
`else
                            state     <= DONE;
                            msg_valid <= 1'b1;
                            msg_type  <= type_sh;
                            price     <= price_sh;
                            qty       <= {qty_sh[7:0], r_data};
`endif
                        end
                    end
`ifdef UART_MSG_PARSER_CHKSUM_EN
                    CHK: begin
                        if (r_data == xsum) begin
                            state     <= DONE;
                            msg_valid <= 1'b1;
                            msg_type  <= type_sh;
                            price     <= price_sh;
                            qty       <= qty_sh;
                        end else begin
                            state   <= HUNT;
                            err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
                        end
                    end
`endif
                    // HUNT and DONE both look for the next sync byte.
                    default: state <= (r_data == SYNC_BYTE) ? TYPE : HUNT;
                endcase
            end else if (state == DONE) begin
                state <= HUNT;
            end
        end
    end
endmodule
